// File: rtl/maple_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : maple_bus_pkg
// Brief  : Shared Maple Bus constants: FSM one-hot encodings, default pulse
//          counts for start/end frame patterns, and the idle line level.
// Rev    : 1.0  initial release
// ============================================================================
package maple_bus_pkg;

  // One-hot encoding of the frame pattern decoder states
  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_START_CNT = 5'b00010,
    ST_END_CNT   = 5'b00100,
    ST_WAIT_IDLE = 5'b01000
  } state_t;

  // SDCKB falls needed while SDCKA is low to form a start pattern
  localparam int c_default_start_pulses = 4;
  // SDCKA falls needed while SDCKB is low to form an end pattern
  localparam int c_default_end_pulses   = 2;
  // Both bus lines rest high between frames
  localparam logic c_line_idle = 1'b1;

endpackage
`default_nettype wire

// File: rtl/maple_line_sync.sv
`default_nettype none
// ============================================================================
// Module : maple_line_sync
// Brief  : Two-flop synchroniser plus history register for one raw bus line.
//          Level and edge strobes are registered and mutually aligned, so
//          in the cycle a strobe is high the level already shows the new value.
// Rev    : 1.0  initial release
// ============================================================================
module maple_line_sync
  import maple_bus_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronise the raw line, keep one cycle of history, register the edges
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_meta <= c_line_idle;
      r_sync <= c_line_idle;
      r_prev <= c_line_idle;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_meta <= line_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
      rise   <= r_sync & ~r_prev;
      fall   <= ~r_sync & r_prev;
    end
  end

  assign level = r_prev;

endmodule
`default_nettype wire

// File: rtl/frame_pattern_decoder.sv
`default_nettype none
// ============================================================================
// Module : frame_pattern_decoder
// Brief  : Recognises Maple Bus start-of-frame and end-of-frame line patterns
//          on SDCKA/SDCKB and emits one-cycle detect / error pulses.
// Rev    : 1.0  initial release
// ============================================================================
module frame_pattern_decoder
  import maple_bus_pkg::*;
#(
  parameter int START_PULSES = c_default_start_pulses,
  parameter int END_PULSES   = c_default_end_pulses,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic sdcka_in,
  input  logic sdckb_in,
  output logic start_det,
  output logic end_det,
  output logic pattern_err,
  output logic busy
);

  localparam logic [CNT_W-1:0] c_cnt_max      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_tmo_last     = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_start_target = CNT_W'(START_PULSES);
  localparam logic [CNT_W-1:0] c_end_target   = CNT_W'(END_PULSES);

  logic w_a_lvl, w_a_rise, w_a_fall;
  logic w_b_lvl, w_b_rise, w_b_fall;

  maple_line_sync u_sync_a (
    .clk     (clk),
    .reset   (reset),
    .line_in (sdcka_in),
    .level   (w_a_lvl),
    .rise    (w_a_rise),
    .fall    (w_a_fall)
  );

  maple_line_sync u_sync_b (
    .clk     (clk),
    .reset   (reset),
    .line_in (sdckb_in),
    .level   (w_b_lvl),
    .rise    (w_b_rise),
    .fall    (w_b_fall)
  );

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_tmo;

  logic             w_in_start;
  logic             w_term;
  logic             w_term_other_hi;
  logic             w_count;
  logic             w_any_edge;
  logic [CNT_W-1:0] w_target;

  // Start and end counting are mirror images; pick the lines for the active one
  always_comb begin
    w_in_start      = (r_state == ST_START_CNT);
    w_term          = w_in_start ? w_a_rise : w_b_rise;
    w_term_other_hi = w_in_start ? w_b_lvl  : w_a_lvl;
    w_count         = w_in_start ? (w_b_fall & ~w_a_lvl) : (w_a_fall & ~w_b_lvl);
    w_target        = w_in_start ? c_start_target : c_end_target;
    w_any_edge      = w_a_rise | w_a_fall | w_b_rise | w_b_fall;
  end

  // Pattern FSM with pulse counter, inactivity timeout and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_tmo       <= '0;
      start_det   <= 1'b0;
      end_det     <= 1'b0;
      pattern_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start_det   <= 1'b0;
      end_det     <= 1'b0;
      pattern_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          r_tmo <= '0;
          if (enable) begin
            if (w_a_fall && w_b_fall) begin
              pattern_err <= 1'b1;
              r_state     <= ST_WAIT_IDLE;
              busy        <= 1'b1;
            end else if (w_a_fall && w_b_lvl) begin
              r_state <= ST_START_CNT;
              busy    <= 1'b1;
            end else if (w_b_fall && w_a_lvl) begin
              r_state <= ST_END_CNT;
              busy    <= 1'b1;
            end
          end
        end
        ST_START_CNT, ST_END_CNT: begin
          if (w_term) begin
            r_tmo <= '0;
            if (w_term_other_hi && (r_cnt == w_target)) begin
              start_det <= w_in_start;
              end_det   <= ~w_in_start;
              r_state   <= ST_IDLE;
              busy      <= 1'b0;
            end else begin
              pattern_err <= 1'b1;
              r_state     <= ST_WAIT_IDLE;
            end
          end else begin
            if (w_count && (r_cnt != c_cnt_max)) begin
              r_cnt <= r_cnt + 1'b1;
            end
            if (w_any_edge) begin
              r_tmo <= '0;
            end else if (r_tmo >= c_tmo_last) begin
              r_tmo       <= '0;
              pattern_err <= 1'b1;
              r_state     <= ST_WAIT_IDLE;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end
        ST_WAIT_IDLE: begin
          r_tmo <= '0;
          if (w_a_lvl && w_b_lvl) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_pattern_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_frame_pattern_decoder
// Brief  : Scoreboard bench for frame_pattern_decoder. Stimulus pushes the
//          expected pulse kind (and its cycle, where fixed) into a queue; a
//          monitor pops and compares whenever the DUT raises a pulse.
// Rev    : 1.0  initial release
// ============================================================================
module tb_frame_pattern_decoder;

  localparam int K_START = 0;
  localparam int K_END   = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  exp_t exp_q[$];

  logic clk      = 1'b0;
  logic reset    = 1'b0;
  logic enable   = 1'b1;
  logic sdcka_in = 1'b1;
  logic sdckb_in = 1'b1;
  logic start_det, end_det, pattern_err, busy;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   mon_got;
  int   mon_hot;
  exp_t mon_e;

  frame_pattern_decoder #(
    .START_PULSES (4),
    .END_PULSES   (2),
    .TIMEOUT      (255),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sdcka_in    (sdcka_in),
    .sdckb_in    (sdckb_in),
    .start_det   (start_det),
    .end_det     (end_det),
    .pattern_err (pattern_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (start_det || end_det || pattern_err) begin
      mon_hot = int'(start_det) + int'(end_det) + int'(pattern_err);
      mon_got = start_det ? K_START : (end_det ? K_END : K_ERR);
      n_cmp++;
      if (mon_hot > 1) begin
        n_bad++;
        $display("FAIL pulse_onehot @%0d: got %0d pulses high, required 1", cyc, mon_hot);
      end else if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse @%0d: got kind %0d, required no pulse", cyc, mon_got);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != mon_got || (mon_e.cyc >= 0 && mon_e.cyc != cyc)) begin
          n_bad++;
          $display("FAIL pulse: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                   mon_got, cyc, mon_e.kind, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected pulse lat cycles after the edge driven now; lat<0 = any time
  task automatic expect_pulse(input int kind, input int lat);
    exp_t e;
    e.kind = kind;
    e.cyc  = (lat < 0) ? -1 : cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic b_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sdckb_in = 1'b0; wait_cyc(8);
      sdckb_in = 1'b1; wait_cyc(8);
    end
  endtask

  task automatic a_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sdcka_in = 1'b0; wait_cyc(8);
      sdcka_in = 1'b1; wait_cyc(8);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_start_det"},   int'(start_det),   0);
    check({tag, "_end_det"},     int'(end_det),     0);
    check({tag, "_pattern_err"}, int'(pattern_err), 0);
    check({tag, "_busy"},        int'(busy),        0);
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b0;
    wait_cyc(5);
    check_outputs_zero("reset");
    reset = 1'b1;
    wait_cyc(5);

    // Valid start: A low, 4 B pulses, A high
    sdcka_in = 1'b0; wait_cyc(8);
    b_pulses(4);
    sdcka_in = 1'b1;
    expect_pulse(K_START, 4);
    wait_cyc(3);
    check("start_busy_before_det", int'(busy), 1);
    wait_cyc(12);
    check("start_busy_after", int'(busy), 0);

    // Valid end: B low, 2 A pulses, B high
    sdckb_in = 1'b0;
    wait_cyc(6);
    check("end_busy_in_pattern", int'(busy), 1);
    a_pulses(2);
    sdckb_in = 1'b1;
    expect_pulse(K_END, 4);
    wait_cyc(3);
    check("end_busy_before_det", int'(busy), 1);
    wait_cyc(1);
    check("end_busy_at_det", int'(busy), 0);
    wait_cyc(10);

    // Short start: only 3 B pulses
    sdcka_in = 1'b0; wait_cyc(8);
    b_pulses(3);
    sdcka_in = 1'b1;
    expect_pulse(K_ERR, 4);
    wait_cyc(4);
    check("short_busy_at_err", int'(busy), 1);
    wait_cyc(1);
    check("short_busy_idle", int'(busy), 0);
    wait_cyc(10);

    // Timeout: A low, 1 B pulse, then lines frozen
    sdcka_in = 1'b0; wait_cyc(8);
    b_pulses(1);
    expect_pulse(K_ERR, -1);
    wait_cyc(200);
    check("tmo_not_early", exp_q.size(), 1);
    wait_cyc(100);
    check("tmo_fired", exp_q.size(), 0);
    check("tmo_busy_wait_idle", int'(busy), 1);
    sdcka_in = 1'b1;
    wait_cyc(10);
    check("tmo_busy_idle", int'(busy), 0);

    // Simultaneous A/B fall from idle
    sdcka_in = 1'b0; sdckb_in = 1'b0;
    expect_pulse(K_ERR, 4);
    wait_cyc(10);
    sdcka_in = 1'b1; sdckb_in = 1'b1;
    wait_cyc(10);
    check("simul_busy_idle", int'(busy), 0);

    // Disabled: a valid start pattern must be ignored
    enable = 1'b0;
    sdcka_in = 1'b0; wait_cyc(8);
    b_pulses(2);
    check("disabled_busy_mid", int'(busy), 0);
    b_pulses(2);
    sdcka_in = 1'b1;
    wait_cyc(10);
    check("disabled_busy_end", int'(busy), 0);
    enable = 1'b1;
    wait_cyc(5);

    // Reset in the middle of a start pattern
    sdcka_in = 1'b0; wait_cyc(8);
    b_pulses(2);
    check("midreset_busy_before", int'(busy), 1);
    reset = 1'b0;
    wait_cyc(1);
    check_outputs_zero("midreset");
    sdcka_in = 1'b1;
    wait_cyc(4);
    reset = 1'b1;
    wait_cyc(10);

    // Fresh complete start after the reset
    sdcka_in = 1'b0; wait_cyc(8);
    b_pulses(4);
    sdcka_in = 1'b1;
    expect_pulse(K_START, 4);
    wait_cyc(15);
    check("final_busy_idle", int'(busy), 0);

    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulse: got none, required kind %0d at cycle %0d", mon_e.kind, mon_e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
